// File: rtl/rtc_pkg.sv
// Shared constants and types for the RTC access sequencer: select bit
// indices, bus cycle types, sequence ids, step counts, FSM encoding and the
// step-table record returned by rtc_seq_rom.
package rtc_pkg;

  localparam int unsigned SEL_W  = 13;
  localparam int unsigned STEP_W = 5;
  localparam int unsigned N_REGS = 9;

  // One-hot select bit positions into the RTC address/data mux
  localparam int unsigned SEL_DAT_ESC_INIT = 0;
  localparam int unsigned SEL_DAT_ESC_ZERO = 1;
  localparam int unsigned SEL_DIR_ST2      = 2;
  localparam int unsigned SEL_DIR_COM_CYT  = 3;
  localparam int unsigned SEL_DIR_SEG      = 4;   // first of the 9 time registers
  localparam int unsigned SEL_DIR_HORA_TIM = 12;  // last of the 9 time registers

  localparam logic [1:0] TIPO_DIR = 2'b00;
  localparam logic [1:0] TIPO_WR  = 2'b01;
  localparam logic [1:0] TIPO_RD  = 2'b10;

  localparam logic [3:0] USR_NONE = 4'hF;

  localparam logic [STEP_W-1:0] INIT_STEPS = 5'd4;
  localparam logic [STEP_W-1:0] READ_STEPS = 5'd20;
  localparam logic [STEP_W-1:0] PROG_STEPS = 5'd20;

  typedef enum logic [1:0] {
    SEQ_INIT = 2'd0,
    SEQ_READ = 2'd1,
    SEQ_PROG = 2'd2
  } seq_e;

  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_NEXT    = 3'd4,
    ST_DONE    = 3'd5,
    ST_ABORT   = 3'd6
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [1:0]       tipo;
    logic [3:0]       usr_sel;
    logic [3:0]       cap_idx;
    logic             last;
  } rom_t;

  function automatic logic [SEL_W-1:0] sel_bit(input int unsigned idx);
    return SEL_W'(1) << idx;
  endfunction

endpackage

// File: rtl/rtc_seq_rom.sv
// Step table: maps (sequence id, step) to select, cycle type, user-value
// index, capture slot and last-step flag.
//   i_seq  : sequence id
//   i_step : step number within the sequence
//   o_rom  : step record
module rtc_seq_rom
  import rtc_pkg::*;
(
  input  seq_e              i_seq,
  input  logic [STEP_W-1:0] i_step,
  output rom_t              o_rom
);

  logic [3:0] w_k;  // time-register index for the per-register step pairs

  always_comb begin : p_rom
    o_rom = '{sel: '0, tipo: TIPO_DIR, usr_sel: USR_NONE, cap_idx: '0, last: 1'b1};
    w_k   = '0;
    case (i_seq)
      SEQ_INIT: if (i_step < INIT_STEPS) begin
        o_rom.last = (i_step == INIT_STEPS - 5'd1);
        case (i_step[1:0])
          2'd1: begin
            o_rom.sel  = sel_bit(SEL_DAT_ESC_INIT);
            o_rom.tipo = TIPO_WR;
          end
          2'd3: begin
            o_rom.sel  = sel_bit(SEL_DAT_ESC_ZERO);
            o_rom.tipo = TIPO_WR;
          end
          default: o_rom.sel = sel_bit(SEL_DIR_ST2);
        endcase
      end
      SEQ_READ: if (i_step < READ_STEPS) begin
        o_rom.last = (i_step == READ_STEPS - 5'd1);
        if (i_step == 5'd0) begin
          o_rom.sel = sel_bit(SEL_DIR_COM_CYT);
        end else if (i_step == 5'd1) begin
          o_rom.sel  = sel_bit(SEL_DAT_ESC_ZERO);
          o_rom.tipo = TIPO_WR;
        end else begin
          w_k           = 4'((i_step - 5'd2) >> 1);
          o_rom.sel     = sel_bit(SEL_DIR_SEG + 32'(w_k));
          o_rom.cap_idx = w_k;
          if (i_step[0]) o_rom.tipo = TIPO_RD;
        end
      end
      SEQ_PROG: if (i_step < PROG_STEPS) begin
        o_rom.last = (i_step == PROG_STEPS - 5'd1);
        if (i_step == PROG_STEPS - 5'd2) begin
          o_rom.sel = sel_bit(SEL_DIR_COM_CYT);
        end else if (i_step == PROG_STEPS - 5'd1) begin
          o_rom.sel  = sel_bit(SEL_DAT_ESC_ZERO);
          o_rom.tipo = TIPO_WR;
        end else begin
          w_k       = 4'(i_step >> 1);
          o_rom.sel = sel_bit(SEL_DIR_SEG + 32'(w_k));
          if (i_step[0]) begin
            o_rom.tipo    = TIPO_WR;
            o_rom.usr_sel = w_k;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rtc_access_sequencer.sv
// RTC transaction sequencer: runs power-up init, periodic time read and user
// programming as fixed step sequences against the bus-cycle engine.
//   clk, reset_n         : clock, async active-low reset
//   tick_lectura/prog_req: request pulses (latched 1-deep)
//   bus_done, rd_data    : engine completion pulse and read byte
//   sel, usr_sel         : mux selects / user-value index for program data
//   bus_start, bus_tipo  : engine launch pulse and cycle type
//   seg..hora_tim        : published time snapshot, datos_validos on update
//   busy, init_done, error_to : status
module rtc_access_sequencer
  import rtc_pkg::*;
#(
  parameter logic [15:0] POWERUP_CYCLES = 16'd1000,
  parameter logic [11:0] TIMEOUT_CYCLES = 12'd2048
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_lectura,
  input  logic             prog_req,
  input  logic             bus_done,
  input  logic [7:0]       rd_data,
  output logic [SEL_W-1:0] sel,
  output logic [3:0]       usr_sel,
  output logic             bus_start,
  output logic [1:0]       bus_tipo,
  output logic [7:0]       seg,
  output logic [7:0]       min,
  output logic [7:0]       hora,
  output logic [7:0]       dia,
  output logic [7:0]       mes,
  output logic [7:0]       anio,
  output logic [7:0]       seg_tim,
  output logic [7:0]       min_tim,
  output logic [7:0]       hora_tim,
  output logic             datos_validos,
  output logic             busy,
  output logic             init_done,
  output logic             error_to
);

  state_e            r_state, w_state_d;
  seq_e              r_seq, w_seq_d;
  logic [STEP_W-1:0] r_step, w_step_d;
  logic [15:0]       r_cnt, w_cnt_d;   // shared power-up / timeout counter
  logic              r_pend_rd, r_pend_pg, w_clr_rd, w_clr_pg;
  rom_t              w_rom;

  logic [SEL_W-1:0]  r_sel;
  logic [3:0]        r_usr_sel, r_cap;
  logic [1:0]        r_tipo;
  logic              r_bus_start, r_last, r_valid, r_busy, r_init_done, r_error_to;
  logic [7:0]        r_shadow [N_REGS];
  logic [7:0]        r_snap   [N_REGS];

  // Table lookup on the step about to be issued so selects register into ISSUE
  rtc_seq_rom u_rom (
    .i_seq  (w_seq_d),
    .i_step (w_step_d),
    .o_rom  (w_rom)
  );

  // FSM state register and request flags
  always_ff @(posedge clk or negedge reset_n) begin : p_state
    if (!reset_n) begin
      r_state   <= ST_POWERUP;
      r_seq     <= SEQ_INIT;
      r_step    <= '0;
      r_cnt     <= '0;
      r_pend_rd <= 1'b0;
      r_pend_pg <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_seq     <= w_seq_d;
      r_step    <= w_step_d;
      r_cnt     <= w_cnt_d;
      r_pend_rd <= (r_pend_rd & ~w_clr_rd) | tick_lectura;
      r_pend_pg <= (r_pend_pg & ~w_clr_pg) | prog_req;
    end
  end

  // Next-state logic
  always_comb begin : p_next
    w_state_d = r_state;
    w_seq_d   = r_seq;
    w_step_d  = r_step;
    w_cnt_d   = r_cnt;
    w_clr_rd  = 1'b0;
    w_clr_pg  = 1'b0;
    case (r_state)
      ST_POWERUP: begin
        if (r_cnt == POWERUP_CYCLES - 16'd1) begin
          w_state_d = ST_ISSUE;
          w_seq_d   = SEQ_INIT;
          w_step_d  = '0;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      ST_IDLE: begin
        if (r_pend_pg) begin
          w_state_d = ST_ISSUE;
          w_seq_d   = SEQ_PROG;
          w_step_d  = '0;
          w_clr_pg  = 1'b1;
        end else if (r_pend_rd) begin
          w_state_d = ST_ISSUE;
          w_seq_d   = SEQ_READ;
          w_step_d  = '0;
          w_clr_rd  = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_state_d = ST_WAIT;
        w_cnt_d   = '0;
      end
      ST_WAIT: begin
        if (bus_done) begin
          w_state_d = ST_NEXT;
        end else if (r_cnt == 16'(TIMEOUT_CYCLES) - 16'd1) begin
          w_state_d = ST_ABORT;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      ST_NEXT: begin
        if (r_last) begin
          w_state_d = ST_DONE;
        end else begin
          w_state_d = ST_ISSUE;
          w_step_d  = r_step + 5'd1;
        end
      end
      ST_DONE: w_state_d = ST_IDLE;
      ST_ABORT: begin
        // A failed init retries from the power-up wait
        if (r_seq == SEQ_INIT) begin
          w_state_d = ST_POWERUP;
          w_cnt_d   = '0;
        end else begin
          w_state_d = ST_IDLE;
        end
      end
      default: begin
        w_state_d = ST_POWERUP;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs, read capture and snapshot publication
  always_ff @(posedge clk or negedge reset_n) begin : p_out
    if (!reset_n) begin
      r_sel       <= '0;
      r_usr_sel   <= USR_NONE;
      r_tipo      <= TIPO_DIR;
      r_cap       <= '0;
      r_last      <= 1'b0;
      r_bus_start <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_init_done <= 1'b0;
      r_error_to  <= 1'b0;
      for (int unsigned i = 0; i < N_REGS; i++) begin
        r_shadow[i] <= '0;
        r_snap[i]   <= '0;
      end
    end else begin
      r_bus_start <= (w_state_d == ST_ISSUE);
      r_busy      <= (w_state_d != ST_IDLE);
      r_valid     <= 1'b0;
      if (w_state_d == ST_ISSUE) begin
        r_sel     <= w_rom.sel;
        r_tipo    <= w_rom.tipo;
        r_usr_sel <= w_rom.usr_sel;
        r_cap     <= w_rom.cap_idx;
        r_last    <= w_rom.last;
      end else if (w_state_d != ST_WAIT && w_state_d != ST_NEXT) begin
        r_sel     <= '0;
        r_tipo    <= TIPO_DIR;
        r_usr_sel <= USR_NONE;
      end
      if (r_state == ST_WAIT && bus_done && r_tipo == TIPO_RD) begin
        r_shadow[r_cap] <= rd_data;
      end
      if (w_state_d == ST_DONE) begin
        r_error_to <= 1'b0;
        if (r_seq == SEQ_READ) begin
          r_snap  <= r_shadow;
          r_valid <= 1'b1;
        end
        if (r_seq == SEQ_INIT) r_init_done <= 1'b1;
      end else if (w_state_d == ST_ABORT) begin
        r_error_to <= 1'b1;
      end
    end
  end

  assign sel           = r_sel;
  assign usr_sel       = r_usr_sel;
  assign bus_start     = r_bus_start;
  assign bus_tipo      = r_tipo;
  assign datos_validos = r_valid;
  assign busy          = r_busy;
  assign init_done     = r_init_done;
  assign error_to      = r_error_to;
  assign seg           = r_snap[0];
  assign min           = r_snap[1];
  assign hora          = r_snap[2];
  assign dia           = r_snap[3];
  assign mes           = r_snap[4];
  assign anio          = r_snap[5];
  assign seg_tim       = r_snap[6];
  assign min_tim       = r_snap[7];
  assign hora_tim      = r_snap[8];

endmodule

// File: tb/tb_rtc_access_sequencer.sv
// Self-checking bench for rtc_access_sequencer: engine responder, start log
// and a sequence/snapshot model built from the step rules.
module tb_rtc_access_sequencer;
  import rtc_pkg::*;

  localparam int PU = 1000;
  localparam int TO = 2048;

  logic        clk = 1'b0;
  logic        reset_n, tick_lectura, prog_req, bus_done;
  logic [7:0]  rd_data;
  logic [12:0] sel;
  logic [3:0]  usr_sel;
  logic        bus_start;
  logic [1:0]  bus_tipo;
  logic [7:0]  seg, min, hora, dia, mes, anio, seg_tim, min_tim, hora_tim;
  logic        datos_validos, busy, init_done, error_to;

  rtc_access_sequencer dut (
    .clk(clk), .reset_n(reset_n), .tick_lectura(tick_lectura), .prog_req(prog_req),
    .bus_done(bus_done), .rd_data(rd_data), .sel(sel), .usr_sel(usr_sel),
    .bus_start(bus_start), .bus_tipo(bus_tipo), .seg(seg), .min(min), .hora(hora),
    .dia(dia), .mes(mes), .anio(anio), .seg_tim(seg_tim), .min_tim(min_tim),
    .hora_tim(hora_tim), .datos_validos(datos_validos), .busy(busy),
    .init_done(init_done), .error_to(error_to)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] sel;
    logic [1:0]  tipo;
    logic [3:0]  usr;
  } step_t;

  typedef struct {
    bit prog;
    bit rd;
    int lat;        // 0: random latency per step
    int exp_valid;
    bit fixed;      // rd_data 0x10..0x18 instead of random
  } vec_t;

  step_t      log_q[$];
  step_t      exp_q[$];
  step_t      init_tbl[4];
  vec_t       vecs[4];
  logic [7:0] rd_val[9];
  logic [71:0] model_snap;
  int         valid_cnt, snap_viol, hold_viol;
  int         eng_lat;
  logic [12:0] hang_sel;
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic logic [71:0] snap();
    return {hora_tim, min_tim, seg_tim, anio, mes, dia, hora, min, seg};
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bus-engine responder and monitor
  initial begin : engine
    int cnt;
    logic [7:0]  data;
    logic [71:0] prev;
    logic        inflight;
    logic [12:0] fsel;
    step_t       st;
    cnt = 0; data = '0; prev = '0; inflight = 1'b0; fsel = '0;
    bus_done = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      bus_done = 1'b0;
      if (!reset_n) begin
        cnt = 0;
        inflight = 1'b0;
      end else begin
        if (datos_validos) valid_cnt++;
        else if (snap() !== prev) snap_viol++;
        if (inflight && sel !== fsel) hold_viol++;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus_done = 1'b1;
            rd_data  = data;
            inflight = 1'b0;
          end
        end
        if (bus_start) begin
          st = '{sel: sel, tipo: bus_tipo, usr: usr_sel};
          log_q.push_back(st);
          data = 8'($urandom);
          if (bus_tipo == TIPO_RD)
            for (int k = 0; k < 9; k++) if (sel[4+k]) data = rd_val[k];
          if (!(hang_sel != 13'd0 && sel == hang_sel && bus_tipo == TIPO_RD)) begin
            cnt      = (eng_lat == 0) ? int'($urandom_range(1, 6)) : eng_lat;
            inflight = 1'b1;
            fsel     = sel;
          end
        end
      end
      prev = snap();
    end
  end

  // Expected step list of a sequence: 0 init, 1 read, 2 prog
  task automatic add_seq(input int s);
    step_t st;
    if (s == 0) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(init_tbl[i]);
    end else if (s == 1) begin
      st = '{sel: 13'h008, tipo: 2'b00, usr: 4'hF}; exp_q.push_back(st);
      st = '{sel: 13'h002, tipo: 2'b01, usr: 4'hF}; exp_q.push_back(st);
      for (int k = 0; k < 9; k++) begin
        st = '{sel: 13'(1 << (4 + k)), tipo: 2'b00, usr: 4'hF}; exp_q.push_back(st);
        st = '{sel: 13'(1 << (4 + k)), tipo: 2'b10, usr: 4'hF}; exp_q.push_back(st);
      end
    end else begin
      for (int k = 0; k < 9; k++) begin
        st = '{sel: 13'(1 << (4 + k)), tipo: 2'b00, usr: 4'hF};  exp_q.push_back(st);
        st = '{sel: 13'(1 << (4 + k)), tipo: 2'b01, usr: 4'(k)}; exp_q.push_back(st);
      end
      st = '{sel: 13'h008, tipo: 2'b00, usr: 4'hF}; exp_q.push_back(st);
      st = '{sel: 13'h002, tipo: 2'b01, usr: 4'hF}; exp_q.push_back(st);
    end
  endtask

  task automatic compare_log(input string tag, input int n_exp);
    check({tag, "_nstarts"}, 72'(log_q.size()), 72'(n_exp));
    for (int i = 0; i < n_exp && i < log_q.size(); i++)
      check($sformatf("%s_step%0d", tag, i), 72'(log_q[i]), 72'(exp_q[i]));
  endtask

  task automatic update_model();
    for (int k = 0; k < 9; k++) model_snap[8*k +: 8] = rd_val[k];
  endtask

  task automatic new_data(input bit fixed);
    for (int k = 0; k < 9; k++) rd_val[k] = fixed ? 8'(8'h10 + k) : 8'($urandom_range(0, 255));
  endtask

  task automatic clear_logs();
    log_q.delete(); exp_q.delete();
    valid_cnt = 0; snap_viol = 0; hold_viol = 0;
  endtask

  task automatic pulse(input bit p, input bit t);
    @(negedge clk); prog_req = p; tick_lectura = t;
    @(negedge clk); prog_req = 1'b0; tick_lectura = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int quiet = 0;
    int n = 0;
    while (quiet < 8 && n < bound) begin
      @(negedge clk); n++;
      if (!busy) quiet++; else quiet = 0;
    end
    check(name, 72'(quiet >= 8), 72'(1));
  endtask

  task automatic wait_starts(input string name, input int target, input int bound);
    int n = 0;
    while (log_q.size() < target && n < bound) begin @(negedge clk); n++; end
    check(name, 72'(log_q.size() >= target), 72'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},       72'(sel), 72'(0));
    check({tag, "_usr_sel"},   72'(usr_sel), 72'(4'hF));
    check({tag, "_bus_start"}, 72'(bus_start), 72'(0));
    check({tag, "_bus_tipo"},  72'(bus_tipo), 72'(0));
    check({tag, "_busy"},      72'(busy), 72'(0));
    check({tag, "_init_done"}, 72'(init_done), 72'(0));
    check({tag, "_error_to"},  72'(error_to), 72'(0));
    check({tag, "_valid"},     72'(datos_validos), 72'(0));
    check({tag, "_snapshot"},  snap(), 72'(0));
  endtask

  // Reset, power-up wait and init; optional read request during power-up
  task automatic do_reset_init(input string tag, input bit tick_pu);
    int n;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs({tag, "_rst"});
    model_snap = '0;
    clear_logs();
    reset_n = 1'b1;
    n = 0;
    while (log_q.size() == 0 && n < PU + 100) begin
      @(negedge clk); n++;
      tick_lectura = (tick_pu && n == 100);
    end
    tick_lectura = 1'b0;
    check({tag, "_powerup_window"}, 72'(n >= PU && n <= PU + 2), 72'(1));
    wait_idle({tag, "_init_idle"}, 3000);
    add_seq(0);
    if (tick_pu) begin add_seq(1); update_model(); end
    compare_log(tag, exp_q.size());
    check({tag, "_init_done"}, 72'(init_done), 72'(1));
    check({tag, "_busy"},      72'(busy), 72'(0));
    check({tag, "_error_to"},  72'(error_to), 72'(0));
    check({tag, "_valid_cnt"}, 72'(valid_cnt), 72'(tick_pu));
    check({tag, "_snapshot"},  snap(), model_snap);
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    init_tbl[0] = '{sel: 13'h004, tipo: 2'b00, usr: 4'hF};
    init_tbl[1] = '{sel: 13'h001, tipo: 2'b01, usr: 4'hF};
    init_tbl[2] = '{sel: 13'h004, tipo: 2'b00, usr: 4'hF};
    init_tbl[3] = '{sel: 13'h002, tipo: 2'b01, usr: 4'hF};
    vecs[0] = '{prog: 1'b0, rd: 1'b1, lat: 3, exp_valid: 1, fixed: 1'b1};
    vecs[1] = '{prog: 1'b1, rd: 1'b0, lat: 1, exp_valid: 0, fixed: 1'b0};
    vecs[2] = '{prog: 1'b1, rd: 1'b1, lat: 3, exp_valid: 1, fixed: 1'b0};
    vecs[3] = '{prog: 1'b0, rd: 1'b1, lat: 0, exp_valid: 1, fixed: 1'b0};

    reset_n = 1'b0; tick_lectura = 1'b0; prog_req = 1'b0;
    eng_lat = 3; hang_sel = '0; model_snap = '0;
    new_data(1'b1);

    do_reset_init("init", 1'b0);

    for (int v = 0; v < 4; v++) begin
      clear_logs();
      eng_lat = vecs[v].lat;
      new_data(vecs[v].fixed);
      pulse(vecs[v].prog, vecs[v].rd);
      wait_idle($sformatf("v%0d_idle", v), 5000);
      if (vecs[v].prog) add_seq(2);
      if (vecs[v].rd) begin add_seq(1); update_model(); end
      compare_log($sformatf("v%0d", v), exp_q.size());
      check($sformatf("v%0d_valid_cnt", v), 72'(valid_cnt), 72'(vecs[v].exp_valid));
      check($sformatf("v%0d_snap_early", v), 72'(snap_viol), 72'(0));
      check($sformatf("v%0d_sel_hold", v), 72'(hold_viol), 72'(0));
      check($sformatf("v%0d_snapshot", v), snap(), model_snap);
      check($sformatf("v%0d_error_to", v), 72'(error_to), 72'(0));
      check($sformatf("v%0d_idle_sel", v), 72'({sel, usr_sel}), 72'({13'h0, 4'hF}));
    end

    // Timeout on the min read step
    begin
      int n;
      clear_logs();
      eng_lat = 3;
      hang_sel = 13'h020;
      new_data(1'b0);
      pulse(1'b0, 1'b1);
      wait_starts("to_reach_step5", 6, 500);
      n = 0;
      while (!error_to && n < TO + 100) begin @(negedge clk); n++; end
      check("to_latency", 72'(n >= TO - 1 && n <= TO + 2), 72'(1));
      wait_idle("to_idle", 500);
      add_seq(1);
      compare_log("to", 6);
      check("to_error_to", 72'(error_to), 72'(1));
      check("to_valid_cnt", 72'(valid_cnt), 72'(0));
      check("to_snapshot_kept", snap(), model_snap);
      check("to_busy", 72'(busy), 72'(0));
      hang_sel = '0;
      clear_logs();
      new_data(1'b0);
      pulse(1'b0, 1'b1);
      wait_idle("to_recover_idle", 5000);
      add_seq(1); update_model();
      compare_log("to_recover", exp_q.size());
      check("to_recover_error_to", 72'(error_to), 72'(0));
      check("to_recover_valid", 72'(valid_cnt), 72'(1));
      check("to_recover_snapshot", snap(), model_snap);
    end

    // Three read requests during a program sequence collapse into one read
    clear_logs();
    eng_lat = 2;
    new_data(1'b0);
    pulse(1'b1, 1'b0);
    wait_starts("dup_p1", 3, 200);
    pulse(1'b0, 1'b1);
    repeat (5) @(negedge clk);
    pulse(1'b0, 1'b1);
    wait_starts("dup_p3", 10, 300);
    pulse(1'b0, 1'b1);
    wait_idle("dup_idle", 5000);
    add_seq(2); add_seq(1); update_model();
    compare_log("dup", exp_q.size());
    check("dup_valid_cnt", 72'(valid_cnt), 72'(1));
    check("dup_snapshot", snap(), model_snap);

    // Reset asserted while step 11 of a read is in flight
    clear_logs();
    eng_lat = 3;
    new_data(1'b0);
    pulse(1'b0, 1'b1);
    wait_starts("mid_reach_step11", 12, 500);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_async");
    check("mid_no_publish", 72'(valid_cnt), 72'(0));
    new_data(1'b0);
    do_reset_init("reinit", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
